// File: rtl/ds_pkg.sv
// Shared types and helpers for the digital-to-stochastic stream generator:
// FSM states, maximal-length LFSR tap masks (4..16 bits) and a width-aware rotate.
package ds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ds_state_e;

  // Bit (t-1) is set for every tap t of a primitive polynomial of degree precision.
  function automatic logic [15:0] lfsr_taps(input int unsigned precision);
    case (precision)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] value, input int unsigned amount,
                                       input int unsigned width);
    logic [15:0] result;
    result = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) begin
        result[4'((i + amount) % width)] = value[4'(i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ds_lfsr.sv
// Fibonacci maximal-length LFSR; advances one state per cycle while step is high.
// A zero seed would lock the register, so it is replaced by 1.
module ds_lfsr
  import ds_pkg::*;
#(
  parameter int unsigned PRECISION = 8,
  parameter int unsigned SEED      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  output logic [PRECISION-1:0] value
);

  localparam logic [15:0]          TAPS_FULL = lfsr_taps(PRECISION);
  localparam logic [PRECISION-1:0] TAPS      = TAPS_FULL[PRECISION-1:0];
  localparam logic [PRECISION-1:0] SEED_BITS = SEED[PRECISION-1:0];
  localparam logic [PRECISION-1:0] INIT      = (SEED_BITS == '0) ? PRECISION'(1) : SEED_BITS;

  logic [PRECISION-1:0] lfsr_q;
  logic [PRECISION-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_q[PRECISION-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/ds_stream_gen.sv
// Multi-channel digital-to-stochastic stream generator with valid/ready on both sides.
// Optional macro DS_BIPOLAR_EN adds a 'bipolar' input selecting offset-binary comparison.
module ds_stream_gen
  import ds_pkg::*;
#(
  parameter int unsigned PRECISION  = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned STREAM_LEN = 256,
  parameter int unsigned SEED       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*PRECISION-1:0] in_data,
  input  logic                          in_valid,
`ifdef DS_BIPOLAR_EN
  input  logic                          bipolar,
`endif
  output logic                          in_ready,
  output logic [CHANNELS-1:0]           out_bits,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned          CNT_W    = $clog2(STREAM_LEN + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(STREAM_LEN - 1);
  localparam logic [PRECISION-1:0] MSB_MASK = {1'b1, {(PRECISION-1){1'b0}}};

  ds_state_e                     state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CHANNELS*PRECISION-1:0] val_q, val_d;
  logic [PRECISION-1:0]          lfsr_value;
  logic [PRECISION-1:0]          bip_mask;
  logic                          running;
  logic                          beat_xfer;
  logic                          accept;

  ds_lfsr #(
    .PRECISION(PRECISION),
    .SEED     (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (beat_xfer),
    .value(lfsr_value)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    running   = (state_q == RUN);
    out_valid = running;
    busy      = running;
    out_last  = running && (cnt_q == LAST_CNT);
    beat_xfer = out_valid && out_ready;
    in_ready  = !running || (beat_xfer && out_last);
    accept    = in_valid && in_ready;
    if (beat_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (out_last) begin
        state_d = IDLE;
      end
    end
    // A new vector on the final beat overrides the return to IDLE.
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      val_d   = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

`ifdef DS_BIPOLAR_EN
  logic bip_q, bip_d;

  always_comb begin
    bip_d = bip_q;
    if (accept) begin
      bip_d = bipolar;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bip_q <= 1'b0;
    end else begin
      bip_q <= bip_d;
    end
  end

  assign bip_mask = bip_q ? MSB_MASK : '0;
`else
  assign bip_mask = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [15:0]          rot_full;
    logic [PRECISION-1:0] thr;
    assign rot_full    = rotl(16'(lfsr_value), c % PRECISION, PRECISION);
    assign thr         = val_q[c*PRECISION +: PRECISION] ^ bip_mask;
    assign out_bits[c] = running && (rot_full < 16'(thr));
  end

endmodule

// File: tb/tb_ds_stream_gen.sv
// Self-checking bench for ds_stream_gen: randomized stalls against a spec-level
// reference model, plus STREAM_LEN==1 and zero-seed LFSR instances.
module tb_ds_stream_gen;

  localparam int P   = 8;
  localparam int C   = 4;
  localparam int LEN = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [C*P-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [C-1:0]   out_bits;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           busy;
  logic           bip_in;

  logic [C*P-1:0] one_in_data;
  logic           one_in_valid;
  logic           one_in_ready;
  logic [C-1:0]   one_out_bits;
  logic           one_out_valid;
  logic           one_out_last;
  logic           one_busy;

  logic           lfsr_step;
  logic [P-1:0]   lfsr_value;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic         m_run;
  int           m_cnt;
  logic [7:0]   m_lfsr;
  logic [7:0]   m_val[C];
  logic         m_bip;
  int           ones[C];
  int           beats;

  ds_stream_gen #(.PRECISION(P), .CHANNELS(C), .STREAM_LEN(LEN), .SEED(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef DS_BIPOLAR_EN
    .bipolar  (bip_in),
`endif
    .in_ready (in_ready),
    .out_bits (out_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  ds_stream_gen #(.PRECISION(P), .CHANNELS(C), .STREAM_LEN(1), .SEED(0)) dut_one (
    .clk      (clk),
    .rst      (rst),
    .in_data  (one_in_data),
    .in_valid (one_in_valid),
`ifdef DS_BIPOLAR_EN
    .bipolar  (1'b0),
`endif
    .in_ready (one_in_ready),
    .out_bits (one_out_bits),
    .out_valid(one_out_valid),
    .out_ready(1'b1),
    .out_last (one_out_last),
    .busy     (one_busy)
  );

  ds_lfsr #(.PRECISION(P), .SEED(0)) lfsr_zero (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .value(lfsr_value)
  );

  // Report any difference between what the DUT shows and what the model predicts.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    chk_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Polynomial x^8 + x^6 + x^5 + x^4 + 1, new bit shifted in at the bottom.
  function automatic logic [7:0] model_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Over a full LFSR period every nonzero value appears once, so a threshold t yields t-1 ones.
  function automatic int exp_ones(input logic [7:0] v, input logic bip);
    logic [7:0] t;
    t = bip ? (v ^ 8'h80) : v;
    return (t == 8'd0) ? 0 : int'(t) - 1;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_lfsr = 8'h01;
    m_bip  = 1'b0;
    for (int c = 0; c < C; c++) m_val[c] = 8'h00;
  endtask

  // One clock of stimulus: drive on the falling edge, check shortly after, then advance the model.
  task automatic applyStimulus(input logic v_rst, input logic v_valid, input logic [31:0] v_data,
                               input logic v_ready, input logic v_bip);
    logic [C-1:0] exp_bits;
    logic         exp_last;
    logic         exp_in_ready;
    logic [7:0]   thr;
    @(negedge clk);
    rst       = v_rst;
    in_valid  = v_valid;
    in_data   = v_data;
    out_ready = v_ready;
    bip_in    = v_bip;
    #2;
    for (int c = 0; c < C; c++) begin
      thr         = m_bip ? (m_val[c] ^ 8'h80) : m_val[c];
      exp_bits[c] = m_run && (rot8(m_lfsr, c) < thr);
    end
    exp_last     = m_run && (m_cnt == LEN - 1);
    exp_in_ready = !m_run || (v_ready && exp_last);
    checkOutput("out_valid", 32'(out_valid), 32'(m_run));
    checkOutput("busy", 32'(busy), 32'(m_run));
    checkOutput("out_last", 32'(out_last), 32'(exp_last));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_in_ready));
    checkOutput("out_bits", 32'(out_bits), 32'(exp_bits));
    if (!v_rst && m_run && v_ready) begin
      for (int c = 0; c < C; c++) ones[c] += int'(out_bits[c]);
      beats++;
    end
    if (v_rst) begin
      model_reset();
    end else begin
      if (m_run && v_ready) begin
        m_lfsr = model_step(m_lfsr);
        if (exp_last) m_run = 1'b0;
        else m_cnt++;
      end
      if (v_valid && exp_in_ready) begin
        m_run = 1'b1;
        m_cnt = 0;
        for (int c = 0; c < C; c++) m_val[c] = v_data[c*8 +: 8];
`ifdef DS_BIPOLAR_EN
        m_bip = v_bip;
`else
        m_bip = 1'b0;
`endif
      end
    end
  endtask

  // Run one conversion; optionally stall, offer a follow-on vector, or abort with reset.
  task automatic run_conv(input logic start, input logic [31:0] vals, input logic stall,
                          input logic nxt_en, input logic [31:0] nxt_vals, input logic bip,
                          input int abort_at);
    logic rdy;
    beats = 0;
    for (int c = 0; c < C; c++) ones[c] = 0;
    if (start) applyStimulus(1'b0, 1'b1, vals, 1'b1, bip);
    for (int n = 0; n < 4000 && beats < LEN; n++) begin
      if (beats == abort_at) begin
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        return;
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(1'b0, nxt_en, nxt_vals, rdy, bip);
    end
    checkOutput("beats", 32'(beats), 32'(LEN));
    for (int c = 0; c < C; c++) begin
      checkOutput($sformatf("ones_ch%0d", c), 32'(ones[c]), 32'(exp_ones(vals[c*8 +: 8], bip)));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   first_ret;
    logic zero_seen;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    bip_in       = 1'b0;
    one_in_valid = 1'b0;
    one_in_data  = '0;
    lfsr_step    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] full-period run, values {0,64,128,255}");
    run_conv(1'b1, 32'hFF80_4000, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] random stalls, values {17,200,3,99}");
    run_conv(1'b1, 32'h6303_C811, 1'b1, 1'b0, 32'h0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] back-to-back conversion");
    run_conv(1'b1, 32'h281E_140A, 1'b0, 1'b1, 32'h00FF_00FF, 1'b0, -1);
    run_conv(1'b0, 32'h00FF_00FF, 1'b1, 1'b0, 32'h0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] reset abort at beat 100");
    run_conv(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 100);
    run_conv(1'b1, 32'h0905_0202, 1'b1, 1'b0, 32'h0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

`ifdef DS_BIPOLAR_EN
    $display("[TB] bipolar run, value 0 on all channels");
    run_conv(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 1'b1, -1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
`endif

    $display("[TB] STREAM_LEN=1 instance with zero seed");
    @(negedge clk);
    #2;
    checkOutput("one_idle_in_ready", 32'(one_in_ready), 32'd1);
    one_in_valid = 1'b1;
    one_in_data  = 32'h0805_0202;
    @(negedge clk);
    one_in_valid = 1'b0;
    #2;
    checkOutput("one_out_valid", 32'(one_out_valid), 32'd1);
    checkOutput("one_out_last", 32'(one_out_last), 32'd1);
    checkOutput("one_out_bits", 32'(one_out_bits), 32'h5);
    checkOutput("one_in_ready_last", 32'(one_in_ready), 32'd1);
    @(negedge clk);
    #2;
    checkOutput("one_after_valid", 32'(one_out_valid), 32'd0);
    checkOutput("one_after_busy", 32'(one_busy), 32'd0);

    $display("[TB] zero-seed LFSR period");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("lfsr0_start", 32'(lfsr_value), 32'd1);
    first_ret = 0;
    zero_seen = 1'b0;
    @(negedge clk);
    lfsr_step = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      #2;
      if (lfsr_value == '0) zero_seen = 1'b1;
      if (lfsr_value == P'(1) && first_ret == 0) first_ret = k;
    end
    lfsr_step = 1'b0;
    checkOutput("lfsr0_never_zero", 32'(zero_seen), 32'd0);
    checkOutput("lfsr0_period", 32'(first_ret), 32'd255);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
